axi_rd_arbiter: RTL
===================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter: MAX_OUT, default 2, maximum outstanding AXI reads per requester (1..3).
REQ-002 aclk  in  1  clock; all logic on rising edge.
REQ-003 aresetn  in  1  synchronous reset, active-low.
REQ-004 inst_req / data_req  in  1  read request from fetch / load side (SRAM-like).
REQ-005 inst_addr / data_addr  in  32  request address.
REQ-006 inst_size / data_size  in  2  log2 bytes per beat.
REQ-007 inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
REQ-008 inst_data_ok / data_data_ok  out  1  read data valid this cycle.
REQ-009 inst_rdata / data_rdata  out  32  read data, direct pass-through of rdata.
REQ-010 arid  out  4  0 = inst, 1 = data.
REQ-011 araddr  out  32 ; arsize  out  3 ; arvalid  out  1 ; arready  in  1  AXI read-address channel.
REQ-012 rid  in  4 ; rdata  in  32 ; rvalid  in  1 ; rready  out  1  AXI read-data channel.

Function
REQ-013 The FSM SHALL have two states: IDLE (no AR pending) and AR_WAIT (arvalid high, awaiting arready).
REQ-014 A requester SHALL be eligible in IDLE when its req=1 and its outstanding count < MAX_OUT.
REQ-015 In IDLE with at least one eligible requester, exactly one SHALL be granted: addr_ok=1 combinationally in that cycle, addr/size/id latched, next state AR_WAIT.
REQ-016 addr_ok SHALL be 0 in AR_WAIT and for any ineligible requester.
REQ-017 In AR_WAIT, arvalid=1 with araddr/arsize/arid held stable from the latch; arsize={1'b0,size}.
REQ-018 arvalid & arready SHALL return the FSM to IDLE; a new grant is possible in that following IDLE cycle, not in the handshake cycle (one-cycle AR bubble).
REQ-019 Per-requester outstanding counter (2 bits): +1 on grant, -1 on rvalid&rready with matching rid[0]; simultaneous +1/-1 leaves it unchanged.
REQ-020 rready SHALL be 1 whenever not in reset.
REQ-021 rvalid with rid[0]=0 SHALL pulse inst_data_ok in the same cycle; rid[0]=1 SHALL pulse data_data_ok; never both.
REQ-022 rvalid for a requester whose counter is 0 SHALL be consumed with no data_ok and no counter change (no underflow).
REQ-023 Counter at MAX_OUT SHALL block grants for that requester only; the other requester may still be granted.
REQ-024 Requests withdrawn before grant SHALL leave no state change.

Reset
REQ-025 On aclk edge with aresetn=0: FSM=IDLE, arvalid=0, araddr=0, arid=0, arsize=0, both counters=0, round-robin pointer=inst-last, all addr_ok/data_ok=0, rready=0.
REQ-026 Reset asserted mid-operation (AR_WAIT or reads outstanding) SHALL abandon all state; responses arriving afterward are dropped per REQ-022.

Configuration
REQ-027 Macro RD_ARB_ROUND_ROBIN_EN defined: on simultaneous eligibility grant the requester not granted last; pointer updates on every grant.
REQ-028 Macro undefined: on simultaneous eligibility the data requester SHALL always win; no pointer register exists.

Verification
REQ-029 Reset, then data_req=1 addr=0x1C000100 size=2, arready=1 next cycle -> data_addr_ok=1 cycle 0; cycle 1 arvalid=1 araddr=0x1C000100 arid=1 arsize=3'b010; cycle 2 IDLE.
REQ-030 inst_req and data_req both high for 4 grants, arready always 1, rvalid returned promptly -> without macro grants D,D,D,D; with macro D,I,D,I.
REQ-031 inst_req held, arready=1, no rvalid, MAX_OUT=2 -> exactly two inst_addr_ok pulses, then stalls; one rvalid rid=0 rdata=0xDEADBEEF -> inst_data_ok=1 inst_rdata=0xDEADBEEF, third grant follows.
REQ-032 arready held 0 for 5 cycles after grant -> arvalid/araddr/arid stable all 5 cycles, no addr_ok on either side.
REQ-033 Grant and matching rvalid in the same cycle with count=1 -> count stays 1.
REQ-034 aresetn=0 during AR_WAIT with one read outstanding, then rvalid rid=1 after release -> arvalid=0, no data_data_ok, counters 0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-requester (fetch/load) arbiter onto a single AXI read channel.
// Define RD_ARB_ROUND_ROBIN_EN for round-robin ties; the default build gives the data side priority.
module axi_rd_arbiter #(
  parameter int unsigned MAX_OUT = 2
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] MaxOut = 2'(MAX_OUT);

  typedef enum logic [0:0] {StIdle, StArWait} state_e;

  state_e      state_q;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [3:0]  arid_q;
  logic [2:0]  arsize_q;
  logic        rready_q;
  logic [1:0]  inst_cnt_q, inst_cnt_d;
  logic [1:0]  data_cnt_q, data_cnt_d;

  logic inst_elig, data_elig;
  logic grant_inst, grant_data, grant;
  logic r_fire, inst_dec, data_dec;

  // Only rid[0] distinguishes the two requesters.
  logic unused_rid;
  assign unused_rid = ^rid[3:1];

  assign inst_elig = aresetn && (state_q == StIdle) && inst_req && (inst_cnt_q < MaxOut);
  assign data_elig = aresetn && (state_q == StIdle) && data_req && (data_cnt_q < MaxOut);

`ifdef RD_ARB_ROUND_ROBIN_EN
  logic last_data_q;

  // On a tie, favour whichever side was not granted most recently.
  assign grant_data = data_elig && (!inst_elig || !last_data_q);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_data_q <= 1'b0;
    end else if (grant) begin
      last_data_q <= grant_data;
    end
  end
`else
  assign grant_data = data_elig;
`endif

  assign grant_inst = inst_elig && !grant_data;
  assign grant      = grant_inst || grant_data;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // Responses for a requester with nothing outstanding are swallowed.
  assign r_fire   = rvalid && rready_q;
  assign inst_dec = r_fire && !rid[0] && (inst_cnt_q != 2'd0);
  assign data_dec = r_fire &&  rid[0] && (data_cnt_q != 2'd0);

  assign inst_data_ok = inst_dec;
  assign data_data_ok = data_dec;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arid    = arid_q;
  assign arsize  = arsize_q;
  assign rready  = rready_q;

  always_comb begin
    inst_cnt_d = inst_cnt_q;
    if (grant_inst && !inst_dec) begin
      inst_cnt_d = inst_cnt_q + 2'd1;
    end else if (inst_dec && !grant_inst) begin
      inst_cnt_d = inst_cnt_q - 2'd1;
    end
  end

  always_comb begin
    data_cnt_d = data_cnt_q;
    if (grant_data && !data_dec) begin
      data_cnt_d = data_cnt_q + 2'd1;
    end else if (data_dec && !grant_data) begin
      data_cnt_d = data_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      inst_cnt_q <= 2'd0;
      data_cnt_q <= 2'd0;
      rready_q   <= 1'b0;
    end else begin
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      rready_q   <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      arid_q    <= 4'd0;
      arsize_q  <= 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_q   <= StArWait;
            arvalid_q <= 1'b1;
            araddr_q  <= grant_data ? data_addr : inst_addr;
            arid_q    <= {3'b000, grant_data};
            arsize_q  <= {1'b0, (grant_data ? data_size : inst_size)};
          end
        end
        StArWait: begin
          if (arready) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
